// File: rtl/hilo_pipe.sv
// Purpose     : carries the EX HI/LO write through EX/MEM and MEM/WB, commits it to arch HI/LO at WB.
// Latency     : write presented at edge N shows on mem_* after N, wb_* after N+1, hi_o/lo_o after N+2.
// Backpressure: per-stage stall vector; a stalled stage feeding an unstalled one emits a bubble.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   stall[5:0]          stage stalls {wb,mem,ex,id,if,pc}; only ex/mem/wb are used here
//   flush               drops every in-flight HI/LO write (arch HI/LO untouched)
//   ex_hi_i/lo_i/whilo_i  EX-stage result triple
//   mem_*_o             EX/MEM register, forwarded back to EX
//   wb_*_o              MEM/WB register, forwarded back to EX
//   hi_o, lo_o          architectural HI/LO
//   commit_cnt_o        number of HI/LO commits since reset (wraps silently)
module hilo_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_hi_i,
  input  logic [DATA_W-1:0] ex_lo_i,
  input  logic              ex_whilo_i,
  output logic [DATA_W-1:0] mem_hi_o,
  output logic [DATA_W-1:0] mem_lo_o,
  output logic              mem_whilo_o,
  output logic [DATA_W-1:0] wb_hi_o,
  output logic [DATA_W-1:0] wb_lo_o,
  output logic              wb_whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [CNT_W-1:0]  commit_cnt_o
);

  // One HI/LO write in flight: the pair plus its enable.
  typedef struct packed {
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  localparam hilo_t HILO_NOP = '0;

  // Stall bits named for readability.
  logic stall_ex;
  logic stall_mem;
  logic stall_wb;

  // Front-end stall bits have no effect on this block.
  logic unused_stall_front;

  hilo_t ex_in;
  hilo_t exmem_q;
  hilo_t exmem_d;
  hilo_t memwb_q;
  hilo_t memwb_d;

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              commit;

  assign stall_ex           = stall[3];
  assign stall_mem          = stall[4];
  assign stall_wb           = stall[5];
  assign unused_stall_front = ^stall[2:0];

  assign ex_in = '{whilo: ex_whilo_i, hi: ex_hi_i, lo: ex_lo_i};

  // EX/MEM next value. Flush outranks every stall combination, so a
  // flushed write can never be resurrected by a simultaneous hold.
  always_comb begin
    exmem_d = exmem_q;
    if (flush) begin
      exmem_d = HILO_NOP;
    end else if (stall_ex && !stall_mem) begin
      exmem_d = HILO_NOP;
    end else if (stall_ex && stall_mem) begin
      exmem_d = exmem_q;
    end else begin
      exmem_d = ex_in;
    end
  end

  // MEM/WB next value, same priority scheme one stage later.
  always_comb begin
    memwb_d = memwb_q;
    if (flush) begin
      memwb_d = HILO_NOP;
    end else if (stall_mem && !stall_wb) begin
      memwb_d = HILO_NOP;
    end else if (stall_mem && stall_wb) begin
      memwb_d = memwb_q;
    end else begin
      memwb_d = exmem_q;
    end
  end

  // Commit uses the MEM/WB contents as they stand before the edge, so the
  // instruction already sitting in WB still retires on a flush edge.
  assign commit = memwb_q.whilo && !stall_wb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_q <= HILO_NOP;
      memwb_q <= HILO_NOP;
    end else begin
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else if (commit) begin
      hi_q  <= memwb_q.hi;
      lo_q  <= memwb_q.lo;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // All outputs come straight from registers: no input-to-output path.
  assign mem_hi_o     = exmem_q.hi;
  assign mem_lo_o     = exmem_q.lo;
  assign mem_whilo_o  = exmem_q.whilo;
  assign wb_hi_o      = memwb_q.hi;
  assign wb_lo_o      = memwb_q.lo;
  assign wb_whilo_o   = memwb_q.whilo;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign commit_cnt_o = cnt_q;

endmodule
